// File: rtl/frame_builder.sv
// Device-to-host response framer: SOF, STATUS, CMD, optional read data, CRC-8.
// Streams one byte per cycle into the UART TX FIFO, stalling while it is full.
module frame_builder #(
   parameter logic [7:0] SOF_DEVICE_TO_HOST = 8'hA5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rsp_valid,
   output logic             rsp_ready,
   input  logic [7:0]       rsp_status,
   input  logic [7:0]       rsp_cmd,
   input  logic [63:0][7:0] rsp_data,
   output logic [7:0]       tx_fifo_data,
   output logic             tx_fifo_wr_en,
   input  logic             tx_fifo_full,
   output logic             frame_done,
   output logic             builder_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SOF,
      S_STATUS,
      S_CMD,
      S_DATA,
      S_CRC
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       crc_q, crc_d;
   logic [5:0]       idx_q, idx_d;
   logic [7:0]       status_q, status_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [63:0][7:0] data_q, data_d;
   logic [6:0]       n_bytes;
   logic [6:0]       len_plus1;
   logic             last_data;

   // CRC-8, poly 0x07, MSB first, no reflection.
   function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] byte_in);
      logic [7:0] c;
      c = crc ^ byte_in;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   always_comb begin
      len_plus1 = {3'b000, cmd_q[3:0]} + 7'd1;
      n_bytes   = 7'd0;
      if (cmd_q[7] && (status_q == 8'h00)) begin
         case (cmd_q[5:4])
            2'b00:   n_bytes = len_plus1;
            2'b01:   n_bytes = len_plus1 << 1;
            2'b10:   n_bytes = len_plus1 << 2;
            default: n_bytes = 7'd0;
         endcase
      end
      last_data = ({1'b0, idx_q} == (n_bytes - 7'd1));
   end

   always_comb begin
      state_d       = state_q;
      crc_d         = crc_q;
      idx_d         = idx_q;
      status_d      = status_q;
      cmd_d         = cmd_q;
      data_d        = data_q;
      rsp_ready     = (state_q == S_IDLE);
      builder_busy  = (state_q != S_IDLE);
      tx_fifo_wr_en = 1'b0;
      tx_fifo_data  = 8'h00;
      frame_done    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rsp_valid) begin
               status_d = rsp_status;
               cmd_d    = rsp_cmd;
               data_d   = rsp_data;
               crc_d    = 8'h00;
               idx_d    = 6'd0;
               state_d  = S_SOF;
            end
         end
         S_SOF: begin
            tx_fifo_data  = SOF_DEVICE_TO_HOST;
            tx_fifo_wr_en = !tx_fifo_full;
            if (tx_fifo_wr_en) state_d = S_STATUS;
         end
         S_STATUS: begin
            tx_fifo_data  = status_q;
            tx_fifo_wr_en = !tx_fifo_full;
            if (tx_fifo_wr_en) begin
               crc_d   = crc8_update(crc_q, status_q);
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            tx_fifo_data  = cmd_q;
            tx_fifo_wr_en = !tx_fifo_full;
            if (tx_fifo_wr_en) begin
               crc_d   = crc8_update(crc_q, cmd_q);
               state_d = (n_bytes == 7'd0) ? S_CRC : S_DATA;
            end
         end
         S_DATA: begin
            tx_fifo_data  = data_q[idx_q];
            tx_fifo_wr_en = !tx_fifo_full;
            if (tx_fifo_wr_en) begin
               crc_d = crc8_update(crc_q, data_q[idx_q]);
               // Index stops at the last byte, so it never passes 63.
               if (last_data) state_d = S_CRC;
               else           idx_d   = idx_q + 6'd1;
            end
         end
         S_CRC: begin
            tx_fifo_data  = crc_q;
            tx_fifo_wr_en = !tx_fifo_full;
            if (tx_fifo_wr_en) begin
               frame_done = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         crc_q   <= 8'h00;
         idx_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         idx_q   <= idx_d;
      end
   end

   // Captured response payload needs no reset; it is only read after a capture.
   always_ff @(posedge clk) begin
      status_q <= status_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
   end

endmodule
